// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin sharing of one external countdown timer.
//
// One requester at a time owns the timer. The owner's load value is
// captured at grant, the timer is started with a single pulse, and when the
// timer's sticky done flag is seen the owner gets a one-cycle ack. The
// round-robin pointer then moves to the owner, so the owner is searched
// last at the next arbitration.
//
// State table:
//   state | meaning
//   IDLE  | no job; arbitrate among req each edge
//   START | tmr_start high this cycle; timer samples it on the next edge
//   WAIT  | waiting for tmr_done; grant held
//   ACK   | ack pulse high this cycle; no arbitration so the owner can drop req
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   req          per-channel service request (level, held until ack)
//   load_val     channel i load value at bits [i*WIDTH +: WIDTH]
//   grant        one-hot owner, high from grant until the ack edge
//   ack          one-cycle completion pulse to the owner
//   busy         high whenever state != IDLE
//   tmr_start    one-cycle start pulse to the timer
//   tmr_load_val value to the timer, captured at grant
//   tmr_done     timer done flag, sticky until the next start

module timer_scheduler #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] load_val,
   output logic [N-1:0]       grant,
   output logic [N-1:0]       ack,
   output logic               busy,
   output logic               tmr_start,
   output logic [WIDTH-1:0]   tmr_load_val,
   input  logic               tmr_done
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

   state_t            state, state_nx;
   logic [IW-1:0]     rr_ptr, rr_ptr_nx;
   logic [IW-1:0]     sel, sel_nx;
   logic [N-1:0]      grant_nx, ack_nx;
   logic              busy_nx, tmr_start_nx;
   logic [WIDTH-1:0]  tmr_load_val_nx;

   logic              found;
   logic [IW-1:0]     pick;
   logic [IW-1:0]     idx_w;
   int                idx;

   // First requester after rr_ptr, wrapping modulo N (N need not be a power of 2).
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      idx   = 0;
      idx_w = '0;
      for (int k = 1; k <= N; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         idx_w = IW'(idx);
         if (!found && req[idx_w]) begin
            found = 1'b1;
            pick  = idx_w;
         end
      end
   end

   always_comb begin
      state_nx        = state;
      rr_ptr_nx       = rr_ptr;
      sel_nx          = sel;
      grant_nx        = grant;
      ack_nx          = '0;
      busy_nx         = busy;
      tmr_start_nx    = 1'b0;
      tmr_load_val_nx = tmr_load_val;
      case (state)
         IDLE: begin
            if (found) begin
               grant_nx        = '0;
               grant_nx[pick]  = 1'b1;
               tmr_load_val_nx = load_val[int'(pick)*WIDTH +: WIDTH];
               tmr_start_nx    = 1'b1;
               busy_nx         = 1'b1;
               sel_nx          = pick;
               state_nx        = START;
            end
         end
         // done is deliberately not looked at here: it may still be the
         // stale flag from the previous job until the timer sees the start.
         START: state_nx = WAIT;
         WAIT: begin
            if (tmr_done) begin
               ack_nx[sel] = 1'b1;
               grant_nx    = '0;
               rr_ptr_nx   = sel;
               state_nx    = ACK;
            end
         end
         ACK: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= IW'(N-1);
         sel          <= '0;
         grant        <= '0;
         ack          <= '0;
         busy         <= 1'b0;
         tmr_start    <= 1'b0;
         tmr_load_val <= '0;
      end else begin
         state        <= state_nx;
         rr_ptr       <= rr_ptr_nx;
         sel          <= sel_nx;
         grant        <= grant_nx;
         ack          <= ack_nx;
         busy         <= busy_nx;
         tmr_start    <= tmr_start_nx;
         tmr_load_val <= tmr_load_val_nx;
      end
   end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: a behavioural timer, a transaction-level
// reference model that predicts grant/busy/start and queues expected acks,
// a monitor that compares at the falling edge, and directed plus random stimulus.

module tb_timer_scheduler;

   localparam int N     = 4;
   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N-1:0]       req = '0;
   logic [N*WIDTH-1:0] load_val = '0;
   logic [N-1:0]       grant, ack;
   logic               busy, tmr_start;
   logic [WIDTH-1:0]   tmr_load_val;
   logic               tmr_done;

   timer_scheduler #(.N(N), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .req(req), .load_val(load_val),
      .grant(grant), .ack(ack), .busy(busy), .tmr_start(tmr_start),
      .tmr_load_val(tmr_load_val), .tmr_done(tmr_done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int ch);
      logic [N-1:0] v;
      v = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   // Timer: start loads and clears done; decrement while >0; then set done.
   logic [WIDTH-1:0] t_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t_cnt    <= '0;
         tmr_done <= 1'b0;
      end else if (tmr_start) begin
         t_cnt    <= tmr_load_val;
         tmr_done <= 1'b0;
      end else if (t_cnt != 0) begin
         t_cnt <= t_cnt - 1'b1;
      end else begin
         tmr_done <= 1'b1;
      end
   end

   // Reference model: a job granted at edge g with load L acks after edge
   // g+L+3 and frees the block at edge g+L+4; arbitration only when free.
   typedef struct {int ch; int cyc;} ack_t;
   ack_t ack_q[$];
   int   cyc = 0;
   int   m_ptr, m_ch, m_len, m_g;
   bit   m_job;
   logic [N-1:0]     exp_grant;
   logic             exp_busy, exp_start;
   logic [WIDTH-1:0] exp_val;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_job = 0; m_ptr = N-1; m_ch = 0; m_len = 0; m_g = 0;
         exp_grant = '0; exp_busy = 0; exp_start = 0; exp_val = '0;
         ack_q.delete();
      end else begin
         cyc++;
         exp_start = 0;
         if (m_job) begin
            if (cyc == m_g + m_len + 4) m_job = 0;
         end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (!m_job && req[c]) begin
                  m_job = 1;
                  m_ch  = c;
               end
            end
            m_g   = cyc;
            m_ptr = m_ch;
            m_len = int'(load_val[m_ch*WIDTH +: WIDTH]);
            exp_val   = load_val[m_ch*WIDTH +: WIDTH];
            exp_start = 1;
            ack_q.push_back('{m_ch, cyc + m_len + 3});
         end
         exp_busy  = m_job;
         exp_grant = (m_job && cyc < m_g + m_len + 3) ? onehot(m_ch) : '0;
      end
   end

   // Monitor
   int served_q[$];
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", busy, exp_busy);
         check("grant", grant, exp_grant);
         check("tmr_start", tmr_start, exp_start);
         check("tmr_load_val", tmr_load_val, exp_val);
         if (tmr_start) begin
            for (int i = 0; i < N; i++) if (grant[i]) served_q.push_back(i);
         end
         while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            check("ack_missing_cycle", cyc, ack_q[0].cyc);
            void'(ack_q.pop_front());
         end
         if (ack != '0) begin
            if (ack_q.size() == 0) begin
               check("ack_unexpected", ack, 0);
            end else begin
               ack_t e;
               e = ack_q.pop_front();
               check("ack_vector", ack, onehot(e.ch));
               check("ack_cycle", cyc, e.cyc);
            end
         end
      end
   end

   bit active [N];

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      req = '0;
      for (int i = 0; i < N; i++) active[i] = 0;
      #1;
      check("rst_grant", grant, 0);
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_tmr_start", tmr_start, 0);
      check("rst_tmr_load_val", tmr_load_val, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic wait_ack(input int ch, input int limit);
      int n;
      n = 0;
      while (!ack[ch] && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!ack[ch]) check("ack_timeout", ch, -1);
   endtask

   task automatic wait_grant(input int ch, input int limit);
      int n;
      n = 0;
      while (!grant[ch] && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!grant[ch]) check("grant_timeout", ch, -1);
   endtask

   task automatic check_order(input string name, input int exp_list[$]);
      check({name, "_count"}, served_q.size(), exp_list.size());
      for (int i = 0; i < exp_list.size() && i < served_q.size(); i++)
         check(name, served_q[i], exp_list[i]);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);

      // single request, L=5
      req = 4'b0001;
      load_val[0*WIDTH +: WIDTH] = 8'd5;
      wait_ack(0, 30);
      req[0] = 1'b0;
      repeat (3) @(negedge clk);

      // zero load on channel 2
      load_val[2*WIDTH +: WIDTH] = 8'd0;
      req[2] = 1'b1;
      wait_ack(2, 20);
      req[2] = 1'b0;
      repeat (3) @(negedge clk);

      // fairness from reset
      do_reset();
      served_q.delete();
      for (int i = 0; i < N; i++) load_val[i*WIDTH +: WIDTH] = 8'd1;
      req = '1;
      for (int s = 0; s < 5; s++) wait_ack(s % N, 30);
      req = '0;
      repeat (3) @(negedge clk);
      check_order("rr_order", '{0, 1, 2, 3, 0});

      // pointer: ch1 served, then ch0 and ch1 together
      served_q.delete();
      req = 4'b0010;
      wait_ack(1, 30);
      req = '0;
      @(negedge clk);
      req = 4'b0011;
      wait_ack(0, 30);
      req[0] = 1'b0;
      wait_ack(1, 30);
      req[1] = 1'b0;
      repeat (3) @(negedge clk);
      check_order("ptr_order", '{1, 0, 1});

      // capture and drop
      load_val[3*WIDTH +: WIDTH] = 8'd6;
      req[3] = 1'b1;
      wait_grant(3, 20);
      @(negedge clk);
      load_val[3*WIDTH +: WIDTH] = 8'd2;
      req[3] = 1'b0;
      wait_ack(3, 30);
      repeat (3) @(negedge clk);

      // reset three cycles into WAIT
      load_val[1*WIDTH +: WIDTH] = 8'd7;
      req[1] = 1'b1;
      wait_grant(1, 20);
      repeat (4) @(negedge clk);
      do_reset();
      load_val[2*WIDTH +: WIDTH] = 8'd3;
      req = 4'b0100;
      wait_ack(2, 30);
      req = '0;
      repeat (3) @(negedge clk);

      // random traffic
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               if ($urandom % 4 == 0) begin
                  active[i] = 1; req[i] = 1'b1;
               end else begin
                  active[i] = 0; req[i] = 1'b0;
               end
            end else if (!active[i] && $urandom % 8 == 0) begin
               active[i] = 1; req[i] = 1'b1;
            end else if (active[i] && grant[i] && req[i] && $urandom % 16 == 0) begin
               req[i] = 1'b0;
            end
            if ($urandom % 4 == 0) load_val[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
         end
      end

      // drain
      for (int t = 0; t < 400; t++) begin
         bit any;
         @(negedge clk);
         any = 0;
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin active[i] = 0; req[i] = 1'b0; end
            any |= active[i];
         end
         if (!any) break;
      end
      repeat (8) @(negedge clk);
      check("drain_pending_acks", ack_q.size(), 0);
      check("drain_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
